// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multi-cycle CPU: opcodes, PC source
// selects and the sequencer state type.
package cpu_pkg;

  localparam logic [2:0] OP_DTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_ORI   = 3'b010;
  localparam logic [2:0] OP_ST    = 3'b011;
  localparam logic [2:0] OP_LD    = 3'b100;
  localparam logic [2:0] OP_BEQZ  = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

endpackage

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback over one shared
// memory port, with a per-access timeout and a retired-instruction counter.
//
// Memory handshake: mem_req is held high until the cycle mem_ready is seen
// high; that cycle completes the access. mem_we is meaningful only with mem_req.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             aluop,
  output logic             reg_dest,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired,
  output state_t           dbg_state
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retired;
  logic              r_err;
  logic              w_retire;
  logic              w_timeout;
  logic              w_at_limit;
  logic              w_mem_req;

  assign w_at_limit = (r_wait == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_timeout = 1'b0;
    w_mem_req = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_INC;
    aluop     = 1'b0;
    reg_dest  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_INC;
          w_next   = S_DECODE;
        end else if (w_at_limit) begin
          w_timeout = 1'b1;
          w_next    = S_ERROR;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          w_next   = S_HALT;
          w_retire = 1'b1;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        aluop = (opcode != OP_DTYPE);
        case (opcode)
          OP_BEQZ: begin
            if (zero) begin
              pc_write = 1'b1;
              pc_src   = PC_BRANCH;
            end
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
          OP_JMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
          OP_DTYPE, OP_ADDI, OP_ORI: w_next = S_WRITEBACK;
          OP_ST, OP_LD:              w_next = S_MEM;
          default:                   w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        iord      = 1'b1;
        aluop     = 1'b1;
        mem_we    = (opcode == OP_ST);
        if (mem_ready) begin
          if (opcode == OP_ST) begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end else begin
            mdr_write = 1'b1;
            w_next    = S_WRITEBACK;
          end
        end else if (w_at_limit) begin
          w_timeout = 1'b1;
          w_next    = S_ERROR;
        end
      end
      S_WRITEBACK: begin
        regwrite = 1'b1;
        reg_dest = (opcode != OP_DTYPE);
        memtoreg = (opcode == OP_LD);
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: halted = 1'b1;
      default: w_next = S_FETCH;
    endcase
    // Reset silences every strobe in the cycle it is sampled, even mid-access.
    if (reset) begin
      w_mem_req = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_INC;
      aluop     = 1'b0;
      reg_dest  = 1'b0;
      memtoreg  = 1'b0;
      regwrite  = 1'b0;
      halted    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      // Waiting only accumulates while a request is outstanding; any other
      // cycle (including completion) leaves the counter clear for the next access.
      if (w_mem_req && !mem_ready && !w_timeout) r_wait <= r_wait + 1'b1;
      else                                       r_wait <= '0;
      if (w_retire)  r_retired <= r_retired + 1'b1;
      if (w_timeout) r_err     <= 1'b1;
    end
  end

  assign mem_req   = w_mem_req;
  assign err       = r_err & ~reset;
  assign retired   = r_retired;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-cycle expected output
// vectors are queued by the driver and compared by a negedge monitor.
module tb_multicycle_sequencer;
  import cpu_pkg::*;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;
  localparam int VW      = CNT_W + 14 + 3;

  localparam logic [13:0] REQ    = 14'h2000;
  localparam logic [13:0] WE     = 14'h1000;
  localparam logic [13:0] IORD   = 14'h0800;
  localparam logic [13:0] IRW    = 14'h0400;
  localparam logic [13:0] MDRW   = 14'h0200;
  localparam logic [13:0] PCW    = 14'h0100;
  localparam logic [13:0] SRC_J  = 14'h0080;
  localparam logic [13:0] SRC_BR = 14'h0040;
  localparam logic [13:0] ALU    = 14'h0020;
  localparam logic [13:0] RDST   = 14'h0010;
  localparam logic [13:0] M2R    = 14'h0008;
  localparam logic [13:0] RW     = 14'h0004;
  localparam logic [13:0] HLT    = 14'h0002;
  localparam logic [13:0] ERR    = 14'h0001;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, mem_we, iord, ir_write, mdr_write, pc_write;
  logic [1:0]       pc_src;
  logic             aluop, reg_dest, memtoreg, regwrite, halted, err;
  logic [CNT_W-1:0] retired;
  state_t           dbg_state;

  logic [VW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_ret;
  int               checks = 0;
  int               errors = 0;
  int               cyc_n  = 0;

  multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write),
    .pc_src(pc_src), .aluop(aluop), .reg_dest(reg_dest), .memtoreg(memtoreg),
    .regwrite(regwrite), .halted(halted), .err(err), .retired(retired),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: vector = {retired, 14 strobes, state}
  always @(negedge clk) begin
    logic [VW-1:0] obs, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {retired, mem_req, mem_we, iord, ir_write, mdr_write, pc_write,
             pc_src, aluop, reg_dest, memtoreg, regwrite, halted, err, dbg_state};
      check($sformatf("cyc%0d", cyc_n), 64'(obs), 64'(e));
    end
    cyc_n++;
  end

  // Driver: apply one cycle of inputs and queue what the outputs must be.
  task automatic step(input logic rdy, input logic rst, input state_t st, input logic [13:0] s);
    reset     = rst;
    mem_ready = rdy;
    exp_q.push_back({exp_ret, s, st});
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [2:0] op, input logic z, input int fw, input int mw);
    logic [13:0] alu;
    opcode = op;
    zero   = z;
    alu    = (op == OP_DTYPE) ? 14'h0 : ALU;
    for (int i = 0; i < fw; i++) step(1'b0, 1'b0, S_FETCH, REQ);
    step(1'b1, 1'b0, S_FETCH, REQ | IRW | PCW);
    step(1'b0, 1'b0, S_DECODE, 14'h0);
    if (op == OP_HALT) begin
      exp_ret++;
      return;
    end
    case (op)
      OP_BEQZ: begin
        step(1'b0, 1'b0, S_EXECUTE, alu | (z ? (PCW | SRC_BR) : 14'h0));
        exp_ret++;
      end
      OP_JMP: begin
        step(1'b0, 1'b0, S_EXECUTE, alu | PCW | SRC_J);
        exp_ret++;
      end
      OP_ST, OP_LD: begin
        step(1'b0, 1'b0, S_EXECUTE, alu);
        for (int i = 0; i < mw; i++)
          step(1'b0, 1'b0, S_MEM, REQ | IORD | ALU | ((op == OP_ST) ? WE : 14'h0));
        if (op == OP_ST) begin
          step(1'b1, 1'b0, S_MEM, REQ | IORD | ALU | WE);
          exp_ret++;
        end else begin
          step(1'b1, 1'b0, S_MEM, REQ | IORD | ALU | MDRW);
          step(1'b0, 1'b0, S_WRITEBACK, RW | RDST | M2R);
          exp_ret++;
        end
      end
      default: begin
        step(1'b0, 1'b0, S_EXECUTE, alu);
        step(1'b0, 1'b0, S_WRITEBACK, RW | ((op == OP_DTYPE) ? 14'h0 : RDST));
        exp_ret++;
      end
    endcase
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = OP_DTYPE;
    zero      = 1'b0;
    exp_ret   = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, S_FETCH, 14'h0);

    // Directed instruction mix, zero-wait and waited memory
    do_instr(OP_DTYPE, 1'b0, 0, 0);
    do_instr(OP_ADDI,  1'b1, 0, 0);
    do_instr(OP_ORI,   1'b0, 1, 0);
    do_instr(OP_LD,    1'b0, 0, 3);
    do_instr(OP_ST,    1'b0, 0, 0);
    do_instr(OP_BEQZ,  1'b1, 0, 0);
    do_instr(OP_BEQZ,  1'b0, 0, 0);
    do_instr(OP_JMP,   1'b0, 3, 0);
    do_instr(OP_ST,    1'b1, 2, 3);

    // Random mix, waits kept below the timeout limit
    for (int i = 0; i < 40; i++)
      do_instr(3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3));

    // Enough jumps to wrap the retired counter
    for (int i = 0; i < 260; i++) do_instr(OP_JMP, 1'b0, 0, 0);

    // Reset in the middle of a load access
    opcode = OP_LD;
    step(1'b1, 1'b0, S_FETCH, REQ | IRW | PCW);
    step(1'b0, 1'b0, S_DECODE, 14'h0);
    step(1'b0, 1'b0, S_EXECUTE, ALU);
    step(1'b0, 1'b0, S_MEM, REQ | IORD | ALU);
    step(1'b0, 1'b1, S_MEM, 14'h0);
    exp_ret = '0;
    do_instr(OP_ADDI, 1'b0, 0, 0);

    // Fetch timeout into ERROR, then recover with reset
    for (int i = 0; i < TIMEOUT; i++) step(1'b0, 1'b0, S_FETCH, REQ);
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b0, S_ERROR, HLT | ERR);
    step(1'b0, 1'b1, S_ERROR, 14'h0);
    exp_ret = '0;
    do_instr(OP_DTYPE, 1'b0, 0, 0);

    // Memory-phase timeout on a load
    opcode = OP_LD;
    step(1'b1, 1'b0, S_FETCH, REQ | IRW | PCW);
    step(1'b0, 1'b0, S_DECODE, 14'h0);
    step(1'b0, 1'b0, S_EXECUTE, ALU);
    for (int i = 0; i < TIMEOUT; i++) step(1'b0, 1'b0, S_MEM, REQ | IORD | ALU);
    step(1'b0, 1'b0, S_ERROR, HLT | ERR);
    step(1'b0, 1'b1, S_ERROR, 14'h0);
    exp_ret = '0;

    // Halt: stays put with only halted high
    do_instr(OP_HALT, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'b0, S_HALT, HLT);

    @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
